// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shift sequencer: shift-op codes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step; reports the bit that falls off the edge.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  shift_op_t        op,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] stepped,
    output logic             bit_out
);

    always_comb begin
        stepped = value;
        bit_out = value[0];
        case (op)
            OP_LSL: begin
                stepped = {value[WIDTH-2:0], 1'b0};
                bit_out = value[WIDTH-1];
            end
            OP_LSR: stepped = {1'b0, value[WIDTH-1:1]};
            OP_ASR: stepped = {value[WIDTH-1], value[WIDTH-1:1]};
            OP_ROR: stepped = {value[0], value[WIDTH-1:1]};
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative LSL/LSR/ASR/ROR operand-2 shifter: one bit per cycle, start/ready/done handshake.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    input  logic             carry_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nx;
    shift_op_t        op_c;
    shift_op_t        op_q;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] count;
    logic             over_q;
    logic [CNT_W-1:0] eff_c;
    logic             over_c;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic             ready_nx;
    logic             done_nx;

    assign op_c = shift_op_t'(op);

    // Effective step count: ROR wraps, the others clamp at WIDTH (over only matters for LSL/LSR carry)
    always_comb begin
        eff_c  = '0;
        over_c = 1'b0;
        if (op_c == OP_ROR) begin
            eff_c = CNT_W'(32'(amount) % WIDTH);
        end else if (32'(amount) > WIDTH) begin
            eff_c  = CNT_W'(WIDTH);
            over_c = (op_c != OP_ASR);
        end else begin
            eff_c = CNT_W'(amount);
        end
    end

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .value   (work),
        .stepped (step_val),
        .bit_out (step_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start) state_nx = (eff_c != '0) ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (count == CNT_W'(1)) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
        if (flush) state_nx = ST_IDLE;
    end

    always_comb begin
        ready_nx = (state_nx == ST_IDLE);
        done_nx  = (state_nx == ST_DONE);
    end

    // Datapath and registered handshake; result/carry_out only move on entry to DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready     <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            work      <= '0;
            count     <= '0;
            op_q      <= OP_LSL;
            over_q    <= 1'b0;
        end else begin
            ready <= ready_nx;
            done  <= done_nx;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        work   <= data_in;
                        op_q   <= op_c;
                        over_q <= over_c;
                        count  <= eff_c;
                        if (eff_c == '0) begin
                            result    <= data_in;
                            carry_out <= carry_in;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!flush) begin
                        work  <= step_val;
                        count <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            result    <= step_val;
                            carry_out <= over_q ? 1'b0 : step_bit;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, hand-written corner sequences, random vs model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [15:0] data_in;
    logic [4:0]  amount;
    logic        carry_in;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic        carry_out;

    int n_cmp = 0;
    int n_bad = 0;

    shift_sequencer #(.WIDTH(16), .AMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .op        (op),
        .data_in   (data_in),
        .amount    (amount),
        .carry_in  (carry_in),
        .ready     (ready),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [4:0]  amt;
        logic        cin;
        logic [15:0] exp_res;
        logic        exp_c;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Counts edges until done is seen (sampled 1 time unit after each edge); -1 on timeout
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                n = i;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [15:0] d, input logic [4:0] a,
                         input logic c, output logic [15:0] r, output logic co, output int lat);
        op = o; data_in = d; amount = a; carry_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        r  = result;
        co = carry_out;
        if (lat < 0) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) cnt++;
            @(posedge clk); #1;
        end
    endtask

    // Reference: ARM shifter rules written as whole-word arithmetic
    function automatic void model(input logic [1:0] o, input logic [15:0] d, input int a,
                                  input logic c, output logic [15:0] r, output logic co,
                                  output int lat);
        int s;
        s = (o == 2'd3) ? (a % 16) : ((a > 16) ? 16 : a);
        lat = s;
        r = d;
        co = c;
        if (s != 0) begin
            case (o)
                2'd0: begin r = d << s; co = d[16 - s]; end
                2'd1: begin r = d >> s; co = d[s - 1]; end
                2'd2: begin r = $signed(d) >>> s; co = d[s - 1]; end
                default: begin r = (d >> s) | (d << (16 - s)); co = d[s - 1]; end
            endcase
            if (a > 16 && (o == 2'd0 || o == 2'd1)) co = 1'b0;
        end
    endfunction

    initial begin
        vec_t        vecs[9];
        logic [15:0] r, er;
        logic        co, ec;
        int          lat, elat, n, cnt;
        logic [1:0]  ro;
        logic [15:0] rd;
        logic [4:0]  ra;
        logic        rc;

        vecs[0] = '{2'd0, 16'hC003, 5'd1,  1'b0, 16'h8006, 1'b1, 1};
        vecs[1] = '{2'd1, 16'hC003, 5'd4,  1'b0, 16'h0C00, 1'b0, 4};
        vecs[2] = '{2'd0, 16'h0001, 5'd16, 1'b0, 16'h0000, 1'b1, 16};
        vecs[3] = '{2'd0, 16'h0001, 5'd17, 1'b1, 16'h0000, 1'b0, 16};
        vecs[4] = '{2'd2, 16'h8000, 5'd20, 1'b0, 16'hFFFF, 1'b1, 16};
        vecs[5] = '{2'd3, 16'h0001, 5'd17, 1'b0, 16'h8000, 1'b1, 1};
        vecs[6] = '{2'd0, 16'h1234, 5'd0,  1'b1, 16'h1234, 1'b1, 0};
        vecs[7] = '{2'd3, 16'h1234, 5'd16, 1'b0, 16'h1234, 1'b0, 0};
        vecs[8] = '{2'd1, 16'hFFFF, 5'd8,  1'b0, 16'h00FF, 1'b1, 8};

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        op = 2'd0; data_in = '0; amount = '0; carry_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].data, vecs[i].amt, vecs[i].cin, r, co, lat);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].exp_res));
            chk($sformatf("vec%0d_carry", i), 32'(co), 32'(vecs[i].exp_c));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
        end

        // Zero amount: ready drops for exactly one cycle
        op = 2'd0; data_in = 16'h1234; amount = 5'd0; carry_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("amt0_ready_low", 32'(ready), 32'd0);
        chk("amt0_done_high", 32'(done), 32'd1);
        @(posedge clk); #1;
        chk("amt0_ready_back", 32'(ready), 32'd1);
        chk("amt0_done_low", 32'(done), 32'd0);

        // Start while busy is ignored and not queued
        op = 2'd1; data_in = 16'hFFFF; amount = 5'd8; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        op = 2'd0; data_in = 16'h0000; amount = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        chk("busy_latency", 32'(3 + n), 32'd8);
        chk("busy_result", 32'(result), 32'h00FF);
        chk("busy_carry", 32'(carry_out), 32'd1);
        @(posedge clk); #1;
        count_dones(20, cnt);
        chk("busy_not_queued", 32'(cnt), 32'd0);

        // Flush mid-shift: back to IDLE, no done, outputs held
        op = 2'd1; data_in = 16'h1234; amount = 5'd8; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ready", 32'(ready), 32'd1);
        chk("flush_done", 32'(done), 32'd0);
        count_dones(20, cnt);
        chk("flush_nodone", 32'(cnt), 32'd0);
        chk("flush_result_held", 32'(result), 32'h00FF);
        chk("flush_carry_held", 32'(carry_out), 32'd1);

        // Flush beats start in IDLE
        op = 2'd0; data_in = 16'h5555; amount = 5'd0; carry_in = 1'b0;
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_ready", 32'(ready), 32'd1);
        count_dones(20, cnt);
        chk("flush_start_nodone", 32'(cnt), 32'd0);
        chk("flush_start_result", 32'(result), 32'h00FF);

        // Asynchronous reset mid-shift
        op = 2'd0; data_in = 16'hABCD; amount = 5'd10; carry_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ready", 32'(ready), 32'd1);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_result", 32'(result), 32'd0);
        chk("async_rst_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        do_op(2'd0, 16'hC003, 5'd1, 1'b0, r, co, lat);
        chk("post_rst_result", 32'(r), 32'h8006);
        chk("post_rst_carry", 32'(co), 32'd1);
        chk("post_rst_latency", 32'(lat), 32'd1);

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            rd = 16'($urandom);
            ra = 5'($urandom_range(0, 31));
            rc = 1'($urandom_range(0, 1));
            model(ro, rd, int'(ra), rc, er, ec, elat);
            do_op(ro, rd, ra, rc, r, co, lat);
            chk($sformatf("rand%0d_result op=%0d d=%h a=%0d", i, ro, rd, ra), 32'(r), 32'(er));
            chk($sformatf("rand%0d_carry op=%0d d=%h a=%0d", i, ro, rd, ra), 32'(co), 32'(ec));
            chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller for the ARM datapath: sequences a 1-bit shift step over N cycles to perform LSL/LSR/ASR/ROR by a register-specified amount.
- Sits between the decode/execute control and the ALU operand-2 path, replacing a wide barrel shifter with an area-cheap iterative unit.
- Produces the shifted operand plus the ARM shifter carry-out.
- Uses a start/ready/done handshake to the execute stage.

Parameters:
- WIDTH, 16, data width in bits.
- AMT_W, 5, shift-amount width. Amounts 0..2^AMT_W-1 are accepted, including values of WIDTH or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a shift; sampled only while ready=1.
- flush  input  1  abort any in-flight shift; return to IDLE with no done.
- op  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- data_in  input  WIDTH  operand to shift.
- amount  input  AMT_W  shift amount.
- carry_in  input  1  current C flag; passed through when the effective amount is 0.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse when result/carry_out become valid.
- result  output  WIDTH  shifted value; held until the next accepted start.
- carry_out  output  1  shifter carry; held with result.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, ready=1, done=0, result=0, carry_out=0, internal count=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On an edge with start=1 and flush=0, capture op, data_in and carry_in into the work register.
  - Compute eff:
    - LSL/LSR/ASR: eff = min(amount, WIDTH). Set the over flag when amount > WIDTH.
    - ROR: eff = amount mod WIDTH.
  - Go to SHIFT if eff>0, otherwise go to DONE.
- SHIFT: each edge applies one step and decrements count.
  - LSL: shift in 0 at the LSB; carry = old MSB.
  - LSR: shift in 0 at the MSB; carry = old LSB.
  - ASR: replicate the MSB; carry = old LSB.
  - ROR: old LSB moves to the MSB; carry = old LSB.
  - When count reaches 1, that step's edge moves to DONE.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- Result and carry update on the edge entering DONE:
  - result = work register.
  - carry_out = carry_in if eff=0, 0 if over=1 (LSL/LSR), otherwise the last shifted-out bit.
  - For ASR, over=1 leaves carry = sign bit, which the clamped steps already produce.
- Latency: start accepted at edge T gives done high in the cycle after edge T+eff. eff=0 gives done right after edge T. Maximum is WIDTH+1 edges.
- start while ready=0 (SHIFT or DONE) is ignored and not queued.
- flush: at the next edge, any state goes to IDLE. result and carry_out keep their previous values and no done is issued. If flush and start are both high in IDLE, flush wins and the start is dropped.
- reset mid-operation immediately forces the reset values; no done.
- result and carry_out change only on the edge entering DONE.

Decomposition:
- Package shift_pkg holds:
  - op encodings: OP_LSL, OP_LSR, OP_ASR, OP_ROR.
  - FSM state encodings: ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step: combinational single-bit shift. Inputs op and a WIDTH-bit value; outputs the stepped value and the shifted-out bit. It is instantiated once inside shift_sequencer.

Test Plan:
1. LSL, data_in=16'hC003, amount=1, carry_in=0 -> done after edge T+1, result=16'h8006, carry_out=1.
2. LSR, 16'hC003, amount=4 -> done after edge T+4, result=16'h0C00, carry_out=0. Then LSL 16'h0001 by 16 -> result=0, carry_out=1. LSL 16'h0001 by 17 -> result=0, carry_out=0.
3. ASR, 16'h8000, amount=20 -> clamped to 16 steps, done after edge T+16, result=16'hFFFF, carry_out=1. ROR 16'h0001 by 17 -> eff=1, result=16'h8000, carry_out=1.
4. Amount 0: LSL 16'h1234, carry_in=1 -> done right after edge T, result=16'h1234, carry_out=1, ready low for exactly one cycle.
5. Busy/flush:
   - LSR 16'hFFFF by 8; pulse start at T+3 -> ignored; result=16'h00FF at T+8.
   - Repeat with flush at T+3 -> IDLE at T+4, no done, result keeps its prior value.
6. Assert reset asynchronously mid-SHIFT -> ready=1, done=0, result=0, carry_out=0 immediately, without waiting for a clock edge. The next start behaves normally.
